// File: rtl/vga_reg_dump_ctrl_if.sv
// rtl/vga_reg_dump_ctrl_if.sv - VGA text-buffer character write port
interface vga_reg_dump_ctrl_if;
    logic [7:0] vga_row;
    logic [7:0] vga_col;
    logic [7:0] vga_data;
    logic       vga_we;
    logic       vga_ready;

    modport master (
        output vga_row,
        output vga_col,
        output vga_data,
        output vga_we,
        input  vga_ready
    );

    modport slave (
        input  vga_row,
        input  vga_col,
        input  vga_data,
        input  vga_we,
        output vga_ready
    );
endinterface

// File: rtl/vga_reg_dump_ctrl.sv
// rtl/vga_reg_dump_ctrl.sv - paced register-file to VGA hex text dump scheduler
module vga_reg_dump_ctrl #(
    parameter int ROW_BASE       = 3,
    parameter int COL_BASE       = 10,
    parameter int REG_COUNT      = 32,
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       auto_refresh,
    output logic [4:0]                 reg_addr,
    input  logic [31:0]                reg_data,
    vga_reg_dump_ctrl_if.master        vga,
    output logic                       busy,
    output logic                       done
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [4:0]    LAST_REG     = 5'(REG_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [4:0]      reg_idx;
    logic [2:0]      digit;
    logic [31:0]     shadow;
    logic [RW-1:0]   refresh_cnt;
    logic            start_pass;
    logic            write_accept;
    logic [3:0]      nibble;

    // Map a nibble to its uppercase ASCII hex character.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // A pass begins on an explicit start or on auto-refresh expiry, only from IDLE.
    assign start_pass   = (state == IDLE) &&
                          (start || (auto_refresh && (refresh_cnt == REFRESH_LAST)));
    assign write_accept = (state == WRITE) && vga.vga_ready;
    // Digit 0 is the most-significant nibble, so index from the top of the shadow.
    assign nibble       = shadow[{~digit, 2'b00} +: 4];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start_pass) next_state = FETCH;
            FETCH: next_state = WRITE;
            WRITE: begin
                if (write_accept && (digit == 3'd7)) begin
                    next_state = (reg_idx == LAST_REG) ? DONE : FETCH;
                end
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Register/digit walk, register snapshot and auto-refresh pacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_idx     <= '0;
            digit       <= '0;
            shadow      <= '0;
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= '0;
            case (state)
                IDLE: begin
                    if (start_pass) begin
                        reg_idx <= '0;
                    end else if (auto_refresh) begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end
                FETCH: begin
                    shadow <= reg_data;
                    digit  <= '0;
                end
                WRITE: begin
                    if (write_accept) begin
                        if (digit != 3'd7) begin
                            digit <= digit + 3'd1;
                        end else if (reg_idx != LAST_REG) begin
                            reg_idx <= reg_idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure functions of state and held registers, so they stay stable while stalled.
    always_comb begin
        reg_addr     = '0;
        vga.vga_row  = '0;
        vga.vga_col  = '0;
        vga.vga_data = '0;
        vga.vga_we   = 1'b0;
        done         = 1'b0;
        busy         = (state != IDLE);
        case (state)
            FETCH: reg_addr = reg_idx;
            WRITE: begin
                vga.vga_we   = 1'b1;
                vga.vga_row  = 8'(ROW_BASE) + {3'b000, reg_idx};
                vga.vga_col  = 8'(COL_BASE) + {5'b00000, digit};
                vga.vga_data = hex_char(nibble);
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_reg_dump_ctrl.sv
// tb/tb_vga_reg_dump_ctrl.sv - self-checking bench for vga_reg_dump_ctrl
module tb_vga_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_refresh = 1'b0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];

    vga_reg_dump_ctrl_if vif();

    assign reg_data = regs[reg_addr];

    vga_reg_dump_ctrl #(.REFRESH_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .auto_refresh (auto_refresh),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .vga          (vif),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [23:0] acc_q[$];
    logic [23:0] exp_q[$];
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_we_cyc = -1;
    int busy_rise_cyc = -1;
    int stall_err = 0;
    bit rand_ready = 1'b0;
    bit scramble = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_busy = 1'b0;
    logic [23:0] prev_out = '0;

    initial begin
        vif.vga_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            vif.vga_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (vif.vga_we && vif.vga_ready)
                acc_q.push_back({vif.vga_row, vif.vga_col, vif.vga_data});
            if (prev_stall && (({vif.vga_row, vif.vga_col, vif.vga_data} !== prev_out) || (vif.vga_we !== 1'b1)))
                stall_err++;
            prev_stall = vif.vga_we && !vif.vga_ready;
            prev_out = {vif.vga_row, vif.vga_col, vif.vga_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (vif.vga_we && first_we_cyc < 0) first_we_cyc = cyc;
            if (busy && !prev_busy) busy_rise_cyc = cyc;
            prev_busy = busy;
            if (scramble && vif.vga_we && vif.vga_row >= 8'd3 && vif.vga_row < 8'd35)
                regs[int'(vif.vga_row) - 3] = $urandom;
        end
    end

    function automatic void build_expected();
        int nib;
        exp_q.delete();
        for (int r = 0; r < 32; r++) begin
            for (int d = 0; d < 8; d++) begin
                nib = int'((regs[r] >> (28 - 4 * d)) & 32'hF);
                exp_q.push_back({8'(3 + r), 8'(10 + d), (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10)});
            end
        end
    endfunction

    function automatic int seq_errors(input int passes);
        int bad = 0;
        for (int i = 0; i < acc_q.size() && i < passes * 256; i++)
            if (acc_q[i] !== exp_q[i % 256]) bad++;
        return bad;
    endfunction

    task automatic clear_obs();
        acc_q.delete();
        done_cnt = 0;
        first_we_cyc = -1;
        stall_err = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_cnt++; if ({vif.vga_we, busy, done} !== 3'b000) $display("FAIL reset_ctrl got %b expected 000", {vif.vga_we, busy, done}); else pass_cnt++;
        chk_cnt++; if ({vif.vga_row, vif.vga_col, vif.vga_data} !== 24'h0) $display("FAIL reset_vga got %h expected 000000", {vif.vga_row, vif.vga_col, vif.vga_data}); else pass_cnt++;
        chk_cnt++; if (reg_addr !== 5'd0) $display("FAIL reset_addr got %0d expected 0", reg_addr); else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_pattern();
        bit ok;
        int n31 = 0;
        int n41 = 0;
        for (int r = 0; r < 32; r++) regs[r] = r * 32'h1111_1111;
        build_expected();
        clear_obs();
        pulse_start();
        wait_done(400, ok);
        chk_cnt++; if (!ok) $display("FAIL pattern_done got timeout expected done"); else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL pattern_busy_fall got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (acc_q.size() != 256) $display("FAIL pattern_count got %0d expected 256", acc_q.size()); else pass_cnt++;
        chk_cnt++; if (seq_errors(1) != 0) $display("FAIL pattern_seq got %0d bad expected 0", seq_errors(1)); else pass_cnt++;
        foreach (acc_q[i]) begin
            if (acc_q[i][23:16] == 8'd4 && acc_q[i][7:0] == 8'h31) n31++;
            if (acc_q[i][23:16] == 8'd13 && acc_q[i][7:0] == 8'h41) n41++;
        end
        chk_cnt++; if (n31 != 8) $display("FAIL row4_ones got %0d expected 8", n31); else pass_cnt++;
        chk_cnt++; if (n41 != 8) $display("FAIL row13_as got %0d expected 8", n41); else pass_cnt++;
        chk_cnt++; if (first_we_cyc - start_cyc != 2) $display("FAIL first_we_latency got %0d expected 2", first_we_cyc - start_cyc); else pass_cnt++;
        chk_cnt++; if (done_cyc - start_cyc != 289) $display("FAIL done_latency got %0d expected 289", done_cyc - start_cyc); else pass_cnt++;
        chk_cnt++; if (done_cnt != 1) $display("FAIL pattern_done_pulses got %0d expected 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_deadbeef();
        bit ok;
        int k = 0;
        int bad = 0;
        logic [7:0] db [8];
        db = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        foreach (regs[i]) regs[i] = $urandom;
        regs[5] = 32'hDEAD_BEEF;
        build_expected();
        clear_obs();
        scramble = 1'b1;
        pulse_start();
        wait_done(400, ok);
        scramble = 1'b0;
        chk_cnt++; if (!ok) $display("FAIL deadbeef_done got timeout expected done"); else pass_cnt++;
        chk_cnt++; if (seq_errors(1) != 0 || acc_q.size() != 256) $display("FAIL snapshot_seq got %0d bad of %0d expected 0 of 256", seq_errors(1), acc_q.size()); else pass_cnt++;
        foreach (acc_q[i]) begin
            if (acc_q[i][23:16] == 8'd8) begin
                if (k > 7 || acc_q[i][15:8] != 8'(10 + k) || acc_q[i][7:0] != db[k]) bad++;
                k++;
            end
        end
        chk_cnt++; if (bad != 0 || k != 8) $display("FAIL row8_deadbeef got %0d bad of %0d expected 0 of 8", bad, k); else pass_cnt++;
    endtask

    task automatic test_stall();
        bit ok;
        foreach (regs[i]) regs[i] = $urandom;
        build_expected();
        clear_obs();
        rand_ready = 1'b1;
        pulse_start();
        wait_done(3000, ok);
        rand_ready = 1'b0;
        chk_cnt++; if (!ok) $display("FAIL stall_done got timeout expected done"); else pass_cnt++;
        chk_cnt++; if (acc_q.size() != 256) $display("FAIL stall_count got %0d expected 256", acc_q.size()); else pass_cnt++;
        chk_cnt++; if (seq_errors(1) != 0) $display("FAIL stall_seq got %0d bad expected 0", seq_errors(1)); else pass_cnt++;
        chk_cnt++; if (stall_err != 0) $display("FAIL stall_stable got %0d glitches expected 0", stall_err); else pass_cnt++;
        chk_cnt++; if (done_cyc - start_cyc <= 289) $display("FAIL stall_slowed got %0d cycles expected more than 289", done_cyc - start_cyc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int n1;
        foreach (regs[i]) regs[i] = $urandom;
        build_expected();
        clear_obs();
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (vif.vga_we && vif.vga_row == 8'd10 && vif.vga_col == 8'd12) begin
                ok = 1'b1;
                break;
            end
        end
        chk_cnt++; if (!ok) $display("FAIL reach_row10 got timeout expected write"); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({vif.vga_we, busy, done, reg_addr} !== 8'h0) $display("FAIL async_ctrl got %h expected 00", {vif.vga_we, busy, done, reg_addr}); else pass_cnt++;
        chk_cnt++; if ({vif.vga_row, vif.vga_col, vif.vga_data} !== 24'h0) $display("FAIL async_vga got %h expected 000000", {vif.vga_row, vif.vga_col, vif.vga_data}); else pass_cnt++;
        n1 = acc_q.size();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk_cnt++; if (done_cnt != 0 || busy !== 1'b0 || acc_q.size() != n1) $display("FAIL abort_quiet got done=%0d busy=%b writes=%0d expected 0 0 %0d", done_cnt, busy, acc_q.size(), n1); else pass_cnt++;
        clear_obs();
        pulse_start();
        wait_done(400, ok);
        chk_cnt++; if (!ok || acc_q.size() == 0 || acc_q[0] !== exp_q[0]) $display("FAIL restart_first got %h expected %h", (acc_q.size() > 0) ? acc_q[0] : 24'hx, exp_q[0]); else pass_cnt++;
        chk_cnt++; if (seq_errors(1) != 0 || acc_q.size() != 256) $display("FAIL restart_seq got %0d bad of %0d expected 0 of 256", seq_errors(1), acc_q.size()); else pass_cnt++;
    endtask

    task automatic test_auto();
        bit ok;
        int d;
        int rise;
        foreach (regs[i]) regs[i] = $urandom;
        build_expected();
        clear_obs();
        @(posedge clk);
        #1 auto_refresh = 1'b1;
        wait_done(500, ok);
        chk_cnt++; if (!ok) $display("FAIL auto_first got timeout expected done"); else pass_cnt++;
        for (int p = 0; p < 2; p++) begin
            d = done_cyc;
            wait_done(500, ok);
            chk_cnt++; if (!ok || busy_rise_cyc - d - 1 != 4) $display("FAIL auto_gap%0d got %0d idle expected 4", p, busy_rise_cyc - d - 1); else pass_cnt++;
        end
        repeat (12) @(negedge clk);
        rise = busy_rise_cyc;
        #1 auto_refresh = 1'b0;
        wait_done(500, ok);
        chk_cnt++; if (!ok) $display("FAIL auto_drop_finish got timeout expected done"); else pass_cnt++;
        repeat (40) @(negedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b0 || busy_rise_cyc != rise) $display("FAIL auto_stop got busy=%b rise=%0d expected 0 %0d", busy, busy_rise_cyc, rise); else pass_cnt++;
        chk_cnt++; if (acc_q.size() != 4 * 256 || seq_errors(4) != 0) $display("FAIL auto_seq got %0d writes %0d bad expected 1024 0", acc_q.size(), seq_errors(4)); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        bit ok = 1'b0;
        foreach (regs[i]) regs[i] = $urandom;
        build_expected();
        clear_obs();
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(10, 40)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk_cnt++; if (!ok) $display("FAIL reach_done got timeout expected done"); else pass_cnt++;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk_cnt++; if (done_cnt != 1 || busy !== 1'b0) $display("FAIL one_pass got done=%0d busy=%b expected 1 0", done_cnt, busy); else pass_cnt++;
        chk_cnt++; if (acc_q.size() != 256 || seq_errors(1) != 0) $display("FAIL one_pass_seq got %0d writes %0d bad expected 256 0", acc_q.size(), seq_errors(1)); else pass_cnt++;
    endtask

    initial begin
        foreach (regs[i]) regs[i] = '0;
        test_reset();
        test_pattern();
        test_deadbeef();
        test_stall();
        test_reset_mid();
        test_auto();
        test_start_ignored();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vga_reg_dump_ctrl.md
Name: vga_reg_dump_ctrl

Overview:
Sequential scheduler that walks the CPU register file and streams each register into the VGA text buffer as 8 uppercase ASCII hex characters, one character write per accepted handshake. It sits between the register-file debug read port and the VGA character-buffer write port, replacing per-pixel combinational lookup with a paced, stallable write sequence. A pass is triggered by a start pulse, or periodically when auto-refresh is enabled.

Parameters:
ROW_BASE, 3, text row of register 0; register r is drawn on row ROW_BASE+r
COL_BASE, 10, text column of the most-significant hex digit
REG_COUNT, 32, registers scanned per pass (indices 0..REG_COUNT-1)
REFRESH_CYCLES, 1000, idle cycles between the end of one auto pass and the next start

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a pass; ignored while busy
auto_refresh  in  1  level; when 1, a new pass starts REFRESH_CYCLES cycles after each pass ends
reg_addr  out  5  register-file debug read address
reg_data  in  32  register-file read data, combinational from reg_addr, valid the same cycle
vga_row  out  8  text row of the current write
vga_col  out  8  text column of the current write
vga_data  out  8  ASCII character of the current write
vga_we  out  1  write request to the VGA text buffer
vga_ready  in  1  buffer accepts the write on a rising edge where vga_we=1 and vga_ready=1
busy  out  1  1 whenever the state is not IDLE
done  out  1  one-cycle pulse when a pass completes

Behaviour:
- Reset (async, rst_n=0): state IDLE; reg_addr=0, vga_row=0, vga_col=0, vga_data=0, vga_we=0, busy=0, done=0; register index, digit index, shadow register and refresh counter all cleared. Reset mid-pass aborts the pass immediately; no further writes occur, and no done pulse is generated.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE: the pass starts when start=1, or when auto_refresh=1 and the refresh counter has reached REFRESH_CYCLES-1. The register index is set to 0 and the state moves to FETCH. The refresh counter increments only in IDLE while auto_refresh=1. It clears on leaving IDLE, or when auto_refresh=0.
- FETCH (1 cycle): reg_addr = register index, and vga_we=0. At the end of the cycle, reg_data is latched into a 32-bit shadow, the digit index is set to 0, and the state moves to WRITE.
- WRITE: vga_we=1, vga_row = ROW_BASE + register index, vga_col = COL_BASE + digit index, vga_data = ASCII of shadow nibble [31-4d : 28-4d] for digit index d.
- Hex encoding: 0x0..0x9 map to 0x30..0x39; 0xA..0xF map to 0x41..0x46.
- Stall: while vga_ready=0, vga_row, vga_col, vga_data and vga_we hold stable, with no retry glitch.
- On an accepted write: if d<7, d increments and the state stays in WRITE. If d=7 and the register index is less than REG_COUNT-1, the index increments and the state goes to FETCH. If d=7 and the index equals REG_COUNT-1, the state goes to DONE.
- DONE (1 cycle): vga_we=0, done=1, busy=1. The next state is IDLE.
- Row and column arithmetic is 8-bit unsigned; there is no wrap for the default parameters (maximum row 34, maximum column 17).
- The register file is sampled once per register, in FETCH. A change to reg_data during that register's WRITE phase does not affect its characters.
- Latency with vga_ready held at 1: first vga_we occurs 2 cycles after the start edge. A full pass takes REG_COUNT*9 cycles, followed by the DONE cycle (289 cycles for the defaults).
- start asserted in the same cycle as DONE is ignored. start asserted in IDLE at the same time as auto-refresh expiry begins exactly one pass.
- auto_refresh deasserted mid-pass does not abort the pass.

Test Plan:
- Reset then start, vga_ready=1, reg r holds 32'h0000_0000 + r*32'h1111_1111 (r=1..15) -> exactly 256 writes. Row 4 (r=1) gives eight 0x31 bytes. Row 13 (r=10) gives eight 0x41 bytes. done pulses at cycle 289; busy falls the next cycle.
- reg 5 = 32'hDEAD_BEEF -> row 8, cols 10..17 carry 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46 in order.
- vga_ready toggles 1,0,0,1 pseudo-randomly -> outputs are stable during every stall, there are no dropped or duplicated characters, and the total accepted count is 256.
- rst_n pulsed low at the third write of row 10 -> all outputs are 0 asynchronously, there is no done pulse, and the state is IDLE. A later start rewrites from row 3, col 10.
- auto_refresh=1, REFRESH_CYCLES=4, start never asserted -> passes begin 4 idle cycles after each done pulse. Dropping auto_refresh mid-pass lets that pass finish, then the block stays idle.
- start re-pulsed during a pass and in the DONE cycle -> ignored, and exactly one pass of 256 writes occurs.
